// File: rtl/phase_drive.sv
// phase_drive: free-running PWM, 2-flop synced halls/brake, six-step commutation into 3 registered high/low pairs.
// Drive regs lag PWM_sig by 1 clk, no backpressure; define PHASE_DRIVE_HALL_ERR_EN for the sticky hall_err output.
module phase_drive #(
  parameter int PWM_W = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hallGrn,
  input  logic             hallYlw,
  input  logic             hallBlu,
  input  logic             brake_n,
  input  logic [PWM_W-1:0] drv_mag,
  output logic             highGrn,
  output logic             lowGrn,
  output logic             highYlw,
  output logic             lowYlw,
  output logic             highBlu,
  output logic             lowBlu,
  output logic             PWM_synch
`ifdef PHASE_DRIVE_HALL_ERR_EN
  ,
  output logic             hall_err
`endif
);

  typedef enum logic [1:0] {
    MODE_Z = 2'd0,
    MODE_F = 2'd1,
    MODE_R = 2'd2
  } mode_t;

  logic [PWM_W-1:0] r_cnt;
  logic [PWM_W-1:0] r_duty;
  logic             r_pwm;
  logic [2:0]       r_hall_s1;
  logic [2:0]       r_hall_s2;
  logic [2:0]       r_rot;
  logic             r_brk_s1;
  logic             r_brk_s2;
  logic [5:0]       r_drv;

  logic             w_synch;
  mode_t            w_mode_g;
  mode_t            w_mode_y;
  mode_t            w_mode_b;
  logic [5:0]       w_drv;

  assign w_synch = (r_cnt == {PWM_W{1'b1}});

  function automatic logic [1:0] phase_out(input mode_t m, input logic pwm);
    logic [1:0] o;
    o = 2'b00;
    case (m)
      MODE_F:  o = {pwm, ~pwm};
      MODE_R:  o = {~pwm, pwm};
      default: o = 2'b00;
    endcase
    return o;
  endfunction

  // rotation_state {Grn,Ylw,Blu}; 000/111 are invalid and leave every phase off
  always_comb begin
    w_mode_g = MODE_Z;
    w_mode_y = MODE_Z;
    w_mode_b = MODE_Z;
    case (r_rot)
      3'b101: begin w_mode_g = MODE_F; w_mode_y = MODE_R; end
      3'b100: begin w_mode_g = MODE_F; w_mode_b = MODE_R; end
      3'b110: begin w_mode_y = MODE_F; w_mode_b = MODE_R; end
      3'b010: begin w_mode_y = MODE_F; w_mode_g = MODE_R; end
      3'b011: begin w_mode_b = MODE_F; w_mode_g = MODE_R; end
      3'b001: begin w_mode_b = MODE_F; w_mode_y = MODE_R; end
      default: ;
    endcase
  end

  always_comb begin
    w_drv = 6'b000000;
    if (!r_brk_s2) begin
      w_drv = {1'b0, r_pwm, 1'b0, r_pwm, 1'b0, r_pwm};
    end else begin
      w_drv = {phase_out(w_mode_g, r_pwm), phase_out(w_mode_y, r_pwm), phase_out(w_mode_b, r_pwm)};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_duty    <= '0;
      r_pwm     <= 1'b0;
      r_hall_s1 <= 3'b000;
      r_hall_s2 <= 3'b000;
      r_rot     <= 3'b000;
      r_brk_s1  <= 1'b1;
      r_brk_s2  <= 1'b1;
      r_drv     <= 6'b000000;
    end else begin
      r_cnt     <= r_cnt + 1'b1;
      r_pwm     <= (r_cnt < r_duty);
      r_hall_s1 <= {hallGrn, hallYlw, hallBlu};
      r_hall_s2 <= r_hall_s1;
      r_brk_s1  <= brake_n;
      r_brk_s2  <= r_brk_s1;
      r_drv     <= w_drv;
      // duty and commutation only change on the period boundary
      if (w_synch) begin
        r_duty <= drv_mag;
        r_rot  <= r_hall_s2;
      end
    end
  end

`ifdef PHASE_DRIVE_HALL_ERR_EN
  logic r_hall_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hall_err <= 1'b0;
    end else if (w_synch && ((r_hall_s2 == 3'b000) || (r_hall_s2 == 3'b111))) begin
      r_hall_err <= 1'b1;
    end
  end

  assign hall_err = r_hall_err;
`endif

  assign highGrn   = r_drv[5];
  assign lowGrn    = r_drv[4];
  assign highYlw   = r_drv[3];
  assign lowYlw    = r_drv[2];
  assign highBlu   = r_drv[1];
  assign lowBlu    = r_drv[0];
  assign PWM_synch = w_synch;

endmodule

// File: tb/tb_phase_drive.sv
// Bench for phase_drive: per-period high/low counts over a table of chained periods, plus brake and reset sequences.
module tb_phase_drive;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hallGrn, hallYlw, hallBlu;
  logic        brake_n;
  logic [10:0] drv_mag;
  logic        highGrn, lowGrn, highYlw, lowYlw, highBlu, lowBlu;
  logic        PWM_synch;
`ifdef PHASE_DRIVE_HALL_ERR_EN
  logic        hall_err;
`endif

  always #5 clk = ~clk;

  phase_drive #(.PWM_W(11)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .hallGrn   (hallGrn),
    .hallYlw   (hallYlw),
    .hallBlu   (hallBlu),
    .brake_n   (brake_n),
    .drv_mag   (drv_mag),
    .highGrn   (highGrn),
    .lowGrn    (lowGrn),
    .highYlw   (highYlw),
    .lowYlw    (lowYlw),
    .highBlu   (highBlu),
    .lowBlu    (lowBlu),
    .PWM_synch (PWM_synch)
`ifdef PHASE_DRIVE_HALL_ERR_EN
    ,
    .hall_err  (hall_err)
`endif
  );

  // exp order: highGrn, lowGrn, highYlw, lowYlw, highBlu, lowBlu (clocks high per period)
  typedef struct packed {
    logic [2:0]       halls;
    logic             brk_n;
    logic [10:0]      mag;
    logic             chk;
    logic [5:0][11:0] exp;
  } row_t;

  localparam int NROWS = 20;
  row_t  rows [NROWS];
  int    checks   = 0;
  int    failures = 0;
  int    m_cnt [6];
  int    m_ovl;
  string nm [6] = '{"hiG", "loG", "hiY", "loY", "hiB", "loB"};

  function automatic row_t mk(input logic [2:0] h, input logic b, input logic [10:0] m, input logic c,
                              input int hg, input int lg, input int hy, input int ly, input int hb, input int lb);
    row_t r;
    r.halls  = h;
    r.brk_n  = b;
    r.mag    = m;
    r.chk    = c;
    r.exp[0] = 12'(hg);
    r.exp[1] = 12'(lg);
    r.exp[2] = 12'(hy);
    r.exp[3] = 12'(ly);
    r.exp[4] = 12'(hb);
    r.exp[5] = 12'(lb);
    return r;
  endfunction

  function automatic int outs();
    return int'({highGrn, lowGrn, highYlw, lowYlw, highBlu, lowBlu});
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ends on the negedge one clock after the PWM_synch cycle (cnt == 0)
  task automatic align();
    int  n    = 0;
    bit  seen = 1'b0;
    while (n < 4200 && !seen) begin
      @(negedge clk);
      n++;
      if (PWM_synch) seen = 1'b1;
    end
    check("align_synch_seen", int'(seen), 1);
    @(negedge clk);
  endtask

  // samples the 2048 output clocks belonging to one PWM period; chainable
  task automatic measure();
    for (int k = 0; k < 6; k++) m_cnt[k] = 0;
    m_ovl = 0;
    for (int i = 0; i < 2048; i++) begin
      @(negedge clk);
      m_cnt[0] += int'(highGrn);
      m_cnt[1] += int'(lowGrn);
      m_cnt[2] += int'(highYlw);
      m_cnt[3] += int'(lowYlw);
      m_cnt[4] += int'(highBlu);
      m_cnt[5] += int'(lowBlu);
      if ((highGrn && lowGrn) || (highYlw && lowYlw) || (highBlu && lowBlu)) m_ovl++;
    end
  endtask

  task automatic apply_row(input int i);
    {hallGrn, hallYlw, hallBlu} = rows[i].halls;
    brake_n = rows[i].brk_n;
    drv_mag = rows[i].mag;
    measure();
    check($sformatf("row%0d_overlap", i), m_ovl, 0);
    if (rows[i].chk) begin
      for (int k = 0; k < 6; k++)
        check($sformatf("row%0d_%s", i, nm[k]), m_cnt[k], int'(rows[i].exp[k]));
    end
  endtask

  // from reset release: clocks until PWM_synch, and outputs seen high meanwhile
  task automatic count_to_synch(input string tag);
    int n  = 0;
    int hi = 0;
    bit seen = 1'b0;
    while (n < 4200 && !seen) begin
      @(negedge clk);
      n++;
      if (outs() != 0) hi++;
      if (PWM_synch) seen = 1'b1;
    end
    check({tag, "_first_synch_clk"}, n, 2047);
    check({tag, "_outs_before_synch"}, hi, 0);
    @(negedge clk);
  endtask

  initial begin
    rows[0]  = mk(3'b101, 1'b1, 11'h100, 1'b1, 1024, 1024, 1024, 1024,    0,    0);
    rows[1]  = mk(3'b101, 1'b1, 11'h000, 1'b1,  256, 1792, 1792,  256,    0,    0);
    rows[2]  = mk(3'b101, 1'b1, 11'h7FF, 1'b1,    0, 2048, 2048,    0,    0,    0);
    rows[3]  = mk(3'b101, 1'b1, 11'h100, 1'b1, 2047,    1,    1, 2047,    0,    0);
    rows[4]  = mk(3'b100, 1'b1, 11'h100, 1'b1,  256, 1792, 1792,  256,    0,    0);
    rows[5]  = mk(3'b100, 1'b1, 11'h100, 1'b1,  256, 1792,    0,    0, 1792,  256);
    rows[6]  = mk(3'b110, 1'b1, 11'h100, 1'b1,  256, 1792,    0,    0, 1792,  256);
    rows[7]  = mk(3'b110, 1'b1, 11'h100, 1'b1,    0,    0,  256, 1792, 1792,  256);
    rows[8]  = mk(3'b010, 1'b1, 11'h100, 1'b1,    0,    0,  256, 1792, 1792,  256);
    rows[9]  = mk(3'b010, 1'b1, 11'h100, 1'b1, 1792,  256,  256, 1792,    0,    0);
    rows[10] = mk(3'b011, 1'b1, 11'h100, 1'b1, 1792,  256,  256, 1792,    0,    0);
    rows[11] = mk(3'b011, 1'b1, 11'h100, 1'b1, 1792,  256,    0,    0,  256, 1792);
    rows[12] = mk(3'b001, 1'b1, 11'h100, 1'b1, 1792,  256,    0,    0,  256, 1792);
    rows[13] = mk(3'b001, 1'b1, 11'h200, 1'b1,    0,    0, 1792,  256,  256, 1792);
    rows[14] = mk(3'b001, 1'b0, 11'h200, 1'b1,    0,  512,    0,  512,    0,  512);
    rows[15] = mk(3'b001, 1'b1, 11'h200, 1'b0,    0,    0,    0,    0,    0,    0);
    rows[16] = mk(3'b111, 1'b1, 11'h200, 1'b1,    0,    0, 1536,  512,  512, 1536);
    rows[17] = mk(3'b000, 1'b1, 11'h200, 1'b1,    0,    0,    0,    0,    0,    0);
    rows[18] = mk(3'b101, 1'b1, 11'h400, 1'b1,    0,    0,    0,    0,    0,    0);
    rows[19] = mk(3'b101, 1'b1, 11'h400, 1'b1, 1024, 1024, 1024, 1024,    0,    0);

    rst_n = 1'b0;
    {hallGrn, hallYlw, hallBlu} = 3'b101;
    brake_n = 1'b1;
    drv_mag = 11'h400;
    repeat (3) @(negedge clk);
    check("reset_outs", outs(), 0);
    check("reset_synch", int'(PWM_synch), 0);
`ifdef PHASE_DRIVE_HALL_ERR_EN
    check("reset_hall_err", int'(hall_err), 0);
`endif
    rst_n = 1'b1;
    count_to_synch("start");

    for (int i = 0; i <= 13; i++) apply_row(i);

    // brake mid-period: rotation 001, duty 512, cnt near 100 so PWM_sig is high
    repeat (100) @(negedge clk);
    check("brk_pre_hiB", int'(highBlu), 1);
    brake_n = 1'b0;
    repeat (2) @(negedge clk);
    check("brk_2clk_hiB_still", int'(highBlu), 1);
    @(negedge clk);
    check("brk_3clk_highs", int'({highGrn, highYlw, highBlu}), 0);
    check("brk_3clk_lows", int'({lowGrn, lowYlw, lowBlu}), 7);
    align();

    for (int i = 14; i < NROWS; i++) apply_row(i);
`ifdef PHASE_DRIVE_HALL_ERR_EN
    check("hall_err_sticky", int'(hall_err), 1);
`endif

    // asynchronous reset mid-period while driving
    repeat (100) @(negedge clk);
    check("prerst_hiG", int'(highGrn), 1);
    rst_n = 1'b0;
    #1;
    check("rst_async_outs", outs(), 0);
    check("rst_async_synch", int'(PWM_synch), 0);
`ifdef PHASE_DRIVE_HALL_ERR_EN
    check("rst_hall_err", int'(hall_err), 0);
`endif
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    count_to_synch("rerst");
    measure();
    check("rerst_overlap", m_ovl, 0);
    check("rerst_hiG", m_cnt[0], 1024);
    check("rerst_loY", m_cnt[3], 1024);
    check("rerst_hiB", m_cnt[4], 0);
    check("rerst_loB", m_cnt[5], 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
